// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: req/addr_ok/data_ok data-RAM bus between the MEM stage and memory
interface mem_access_unit_if;
  logic        req;
  logic        wr;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;
  modport master (output req, wr, wstrb, addr, wdata, input addr_ok, data_ok, rdata);
  modport slave  (input req, wr, wstrb, addr, wdata, output addr_ok, data_ok, rdata);
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage data-RAM access FSM with load alignment and pipeline stall
module mem_access_unit #(
  parameter bit ALIGN_ADDR = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      stall_next_stage,
  input  logic                      mem_read_flag_in,
  input  logic                      mem_write_flag_in,
  input  logic                      mem_sign_ext_flag_in,
  input  logic [3:0]                mem_sel_in,
  input  logic [31:0]               mem_write_data_in,
  input  logic [31:0]               result_in,
  output logic [31:0]               result_out,
  output logic                      stall_request,
  mem_access_unit_if.master         ram
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
  state_t      state_q, state_d;
  logic        wr_q, wr_d, sext_q, sext_d;
  logic [3:0]  wstrb_q, wstrb_d, sel_q, sel_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, res_q, res_d, rdata_q, rdata_d;
  logic        access, is_b, is_h;
  logic [7:0]  b;
  logic [15:0] h;
  logic [31:0] load;
  assign access = mem_read_flag_in | mem_write_flag_in;
  // request registers and FSM state; reset aborts any outstanding access at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      wr_q    <= 1'b0;
      sext_q  <= 1'b0;
      wstrb_q <= '0;
      sel_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      res_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      sext_q  <= sext_d;
      wstrb_q <= wstrb_d;
      sel_q   <= sel_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      res_q   <= res_d;
      rdata_q <= rdata_d;
    end
  end
  // next state; request fields latch only when leaving IDLE so the bus stays stable through REQ
  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    sext_d  = sext_q;
    wstrb_d = wstrb_q;
    sel_d   = sel_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    res_d   = res_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: if (access) begin
        state_d = REQ;
        wr_d    = mem_write_flag_in & ~mem_read_flag_in;
        sext_d  = mem_sign_ext_flag_in;
        wstrb_d = (mem_write_flag_in & ~mem_read_flag_in) ? mem_sel_in : 4'b0000;
        sel_d   = mem_sel_in;
        addr_d  = ALIGN_ADDR ? {result_in[31:2], 2'b00} : result_in;
        wdata_d = mem_write_data_in;
        res_d   = result_in;
      end
      REQ: begin
        state_d = !ram.addr_ok ? REQ : ram.data_ok ? DONE : WAIT;
        rdata_d = (ram.addr_ok & ram.data_ok) ? ram.rdata : rdata_q;
      end
      WAIT: begin
        state_d = ram.data_ok ? DONE : WAIT;
        rdata_d = ram.data_ok ? ram.rdata : rdata_q;
      end
      DONE: state_d = stall_next_stage ? DONE : IDLE;
      default: state_d = IDLE;
    endcase
  end
  // lane select and extension of the captured load word
  always_comb begin
    is_b = (sel_q == 4'b0001) | (sel_q == 4'b0010) | (sel_q == 4'b0100) | (sel_q == 4'b1000);
    is_h = (sel_q == 4'b0011) | (sel_q == 4'b1100);
    b    = (sel_q == 4'b0010) ? rdata_q[15:8] : (sel_q == 4'b0100) ? rdata_q[23:16] :
           (sel_q == 4'b1000) ? rdata_q[31:24] : rdata_q[7:0];
    h    = (sel_q == 4'b1100) ? rdata_q[31:16] : rdata_q[15:0];
    load = is_b ? {{24{sext_q & b[7]}}, b} : is_h ? {{16{sext_q & h[15]}}, h} : rdata_q;
  end
  assign ram.req       = (state_q == REQ);
  assign ram.wr        = wr_q;
  assign ram.wstrb     = wstrb_q;
  assign ram.addr      = addr_q;
  assign ram.wdata     = wdata_q;
  assign stall_request = (state_q == IDLE) ? access : (state_q == REQ) | (state_q == WAIT);
  assign result_out    = (state_q != DONE) ? result_in : wr_q ? res_q : load;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed self-checking bench for mem_access_unit
module tb_mem_access_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall_next_stage = 1'b0;
  logic        mem_read_flag_in = 1'b0;
  logic        mem_write_flag_in = 1'b0;
  logic        mem_sign_ext_flag_in = 1'b0;
  logic [3:0]  mem_sel_in = '0;
  logic [31:0] mem_write_data_in = '0;
  logic [31:0] result_in = 32'h55;
  logic [31:0] result_out;
  logic        stall_request;
  int          checks = 0;
  int          errors = 0;
  mem_access_unit_if ram();
  mem_access_unit #(.ALIGN_ADDR(1'b1)) dut (
    .clk(clk), .rst(rst), .stall_next_stage(stall_next_stage),
    .mem_read_flag_in(mem_read_flag_in), .mem_write_flag_in(mem_write_flag_in),
    .mem_sign_ext_flag_in(mem_sign_ext_flag_in), .mem_sel_in(mem_sel_in),
    .mem_write_data_in(mem_write_data_in), .result_in(result_in),
    .result_out(result_out), .stall_request(stall_request), .ram(ram)
  );
  always #5 clk = ~clk;
  initial begin
    ram.addr_ok = 1'b0;
    ram.data_ok = 1'b0;
    ram.rdata   = '0;
  end

  // Presents one access, answers addr_ok at cycle a and data_ok at cycle a+d, returns what was observed
  task automatic access(input logic rd, input logic wr, input logic sx, input logic [3:0] sel,
                        input logic [31:0] wd, input logic [31:0] ad, input logic [31:0] rdat,
                        input int a, input int d, input int hold,
                        output logic [31:0] res, output int stall_n, output int req_n,
                        output bit addr_bad, output bit hold_bad, output bit timeout,
                        output logic wr_s, output logic [3:0] wstrb_s, output logic [31:0] wdata_s);
    logic [31:0] exp_addr;
    exp_addr = {ad[31:2], 2'b00};
    res = '0; stall_n = 0; req_n = 0; addr_bad = 0; hold_bad = 0; timeout = 1;
    wr_s = 0; wstrb_s = '0; wdata_s = '0;
    @(negedge clk);
    mem_read_flag_in = rd; mem_write_flag_in = wr; mem_sign_ext_flag_in = sx;
    mem_sel_in = sel; mem_write_data_in = wd; result_in = ad; ram.rdata = rdat;
    for (int k = 0; k < 30; k++) begin
      if (k > 0) @(negedge clk);
      ram.addr_ok = (k == a);
      ram.data_ok = (k == a + d);
      #1;
      if (k > 0 && !stall_request) begin
        res = result_out; timeout = 0;
        break;
      end
      if (stall_request) stall_n++;
      if (ram.req) begin
        req_n++;
        if (ram.addr !== exp_addr) addr_bad = 1;
        wr_s = ram.wr; wstrb_s = ram.wstrb; wdata_s = ram.wdata;
      end
    end
    mem_read_flag_in = 0; mem_write_flag_in = 0; mem_sign_ext_flag_in = 0;
    ram.addr_ok = 0; ram.data_ok = 0;
    if (!timeout && hold > 0) begin
      stall_next_stage = 1; result_in = 32'hBAD0BAD0;
      repeat (hold) begin
        @(negedge clk); #1;
        if (result_out !== res || stall_request !== 1'b0) hold_bad = 1;
      end
      stall_next_stage = 0;
    end
  endtask

  task automatic test_reset();
    @(negedge clk); #1;
    checks++; if (ram.req !== 1'b0) begin errors++; $display("FAIL reset_req got %b exp 0", ram.req); end
    checks++; if (stall_request !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", stall_request); end
    checks++; if (result_out !== 32'h55) begin errors++; $display("FAIL reset_result got %h exp 00000055", result_out); end
    checks++; if ({ram.wr, ram.wstrb, ram.addr, ram.wdata} !== '0) begin errors++; $display("FAIL reset_bus got %b/%b/%h/%h exp zeros", ram.wr, ram.wstrb, ram.addr, ram.wdata); end
    rst = 0;
  endtask

  task automatic test_alu();
    @(negedge clk);
    result_in = 32'h1234; #1;
    checks++; if (result_out !== 32'h1234) begin errors++; $display("FAIL alu_result got %h exp 00001234", result_out); end
    checks++; if (stall_request !== 1'b0) begin errors++; $display("FAIL alu_stall got %b exp 0", stall_request); end
    checks++; if (ram.req !== 1'b0) begin errors++; $display("FAIL alu_req got %b exp 0", ram.req); end
  endtask

  task automatic test_lw();
    logic [31:0] res, wdat; logic [3:0] ws; logic w; int sn, rn; bit ab, hb, to;
    access(1, 0, 0, 4'b1111, 32'h0, 32'h1006, 32'hDEADBEEF, 1, 0, 0, res, sn, rn, ab, hb, to, w, ws, wdat);
    checks++; if (to || res !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_result got %h timeout %0b exp deadbeef", res, to); end
    checks++; if (sn !== 2) begin errors++; $display("FAIL lw_stall_cycles got %0d exp 2", sn); end
    checks++; if (rn !== 1 || ab) begin errors++; $display("FAIL lw_bus got req %0d addr_bad %0b exp 1/0", rn, ab); end
    checks++; if (w !== 1'b0 || ws !== 4'b0000) begin errors++; $display("FAIL lw_wr got %b/%b exp 0/0000", w, ws); end
  endtask

  task automatic test_load_extract();
    logic [3:0]  sels [7] = '{4'b0100, 4'b0100, 4'b0001, 4'b0011, 4'b1000, 4'b0101, 4'b0010};
    logic        sxs  [7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [31:0] rds  [7] = '{32'h00800000, 32'h00800000, 32'h12345681, 32'h00008001, 32'h7F000000, 32'h80000001, 32'h0000FE00};
    logic [31:0] exps [7] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFFFF81, 32'hFFFF8001, 32'h0000007F, 32'h80000001, 32'h000000FE};
    logic [31:0] res, wdat; logic [3:0] ws; logic w; int sn, rn; bit ab, hb, to;
    for (int i = 0; i < 7; i++) begin
      access(1, 0, sxs[i], sels[i], 32'h0, 32'h400 + i * 4, rds[i], 1, 1, 0, res, sn, rn, ab, hb, to, w, ws, wdat);
      checks++; if (to || res !== exps[i]) begin errors++; $display("FAIL extract_%0d got %h exp %h", i, res, exps[i]); end
    end
  endtask

  task automatic test_lhu_slow();
    logic [31:0] res, wdat; logic [3:0] ws; logic w; int sn, rn; bit ab, hb, to;
    access(1, 0, 0, 4'b1100, 32'h0, 32'h2002, 32'hABCD0000, 3, 2, 0, res, sn, rn, ab, hb, to, w, ws, wdat);
    checks++; if (to || res !== 32'h0000ABCD) begin errors++; $display("FAIL lhu_result got %h exp 0000abcd", res); end
    checks++; if (rn !== 3) begin errors++; $display("FAIL lhu_req_cycles got %0d exp 3", rn); end
    checks++; if (ab) begin errors++; $display("FAIL lhu_addr_stable got unstable exp 00002000"); end
    checks++; if (sn !== 6) begin errors++; $display("FAIL lhu_stall_cycles got %0d exp 6", sn); end
  endtask

  task automatic test_sb();
    logic [31:0] res, wdat; logic [3:0] ws; logic w; int sn, rn; bit ab, hb, to;
    access(0, 1, 0, 4'b0010, 32'h0000AA00, 32'h3001, 32'hFFFFFFFF, 1, 1, 0, res, sn, rn, ab, hb, to, w, ws, wdat);
    checks++; if (w !== 1'b1 || ws !== 4'b0010) begin errors++; $display("FAIL sb_strobe got %b/%b exp 1/0010", w, ws); end
    checks++; if (wdat !== 32'h0000AA00) begin errors++; $display("FAIL sb_wdata got %h exp 0000aa00", wdat); end
    checks++; if (to || res !== 32'h3001) begin errors++; $display("FAIL sb_result got %h exp 00003001", res); end
    checks++; if (sn !== 3 || ab) begin errors++; $display("FAIL sb_stall got %0d addr_bad %0b exp 3/0", sn, ab); end
  endtask

  task automatic test_read_wins();
    logic [31:0] res, wdat; logic [3:0] ws; logic w; int sn, rn; bit ab, hb, to;
    access(1, 1, 0, 4'b1111, 32'h11111111, 32'h500, 32'hCAFEF00D, 1, 0, 0, res, sn, rn, ab, hb, to, w, ws, wdat);
    checks++; if (w !== 1'b0 || ws !== 4'b0000) begin errors++; $display("FAIL readwins_wr got %b/%b exp 0/0000", w, ws); end
    checks++; if (to || res !== 32'hCAFEF00D) begin errors++; $display("FAIL readwins_result got %h exp cafef00d", res); end
  endtask

  task automatic test_done_hold();
    logic [31:0] res, wdat; logic [3:0] ws; logic w; int sn, rn; bit ab, hb, to;
    access(1, 0, 1, 4'b0011, 32'h0, 32'h600, 32'h0000F0F0, 1, 0, 3, res, sn, rn, ab, hb, to, w, ws, wdat);
    checks++; if (to || res !== 32'hFFFFF0F0) begin errors++; $display("FAIL hold_result got %h exp fffff0f0", res); end
    checks++; if (hb) begin errors++; $display("FAIL hold_stable got changed exp fffff0f0 held"); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] r1, r2, wdat; logic [3:0] ws; logic w; int sn, rn; bit ab, hb, t1, t2;
    access(1, 0, 0, 4'b0001, 32'h0, 32'h700, 32'h000000A5, 1, 0, 0, r1, sn, rn, ab, hb, t1, w, ws, wdat);
    access(1, 0, 0, 4'b1000, 32'h0, 32'h704, 32'h5A000000, 1, 0, 0, r2, sn, rn, ab, hb, t2, w, ws, wdat);
    checks++; if (t1 || r1 !== 32'h000000A5) begin errors++; $display("FAIL b2b_first got %h exp 000000a5", r1); end
    checks++; if (t2 || r2 !== 32'h0000005A || sn !== 2) begin errors++; $display("FAIL b2b_second got %h stall %0d exp 0000005a/2", r2, sn); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    mem_read_flag_in = 1; mem_sel_in = 4'b1111; result_in = 32'h3000;
    @(negedge clk);
    ram.addr_ok = 1; #1;
    checks++; if (ram.req !== 1'b1) begin errors++; $display("FAIL rmid_req got %b exp 1", ram.req); end
    @(negedge clk);
    ram.addr_ok = 0; #1;
    checks++; if (ram.req !== 1'b0 || stall_request !== 1'b1) begin errors++; $display("FAIL rmid_wait got req %b stall %b exp 0/1", ram.req, stall_request); end
    mem_read_flag_in = 0; result_in = 32'h77; rst = 1; #1;
    checks++; if (stall_request !== 1'b0 || result_out !== 32'h77) begin errors++; $display("FAIL rmid_async got stall %b res %h exp 0/00000077", stall_request, result_out); end
    @(negedge clk);
    rst = 0; ram.data_ok = 1; ram.rdata = 32'hDEAD0000;
    @(negedge clk);
    ram.data_ok = 0; #1;
    checks++; if (stall_request !== 1'b0 || ram.req !== 1'b0) begin errors++; $display("FAIL rmid_idle got stall %b req %b exp 0/0", stall_request, ram.req); end
    checks++; if (result_out !== 32'h77) begin errors++; $display("FAIL rmid_result got %h exp 00000077", result_out); end
    checks++; if (ram.addr !== 32'h0) begin errors++; $display("FAIL rmid_addr got %h exp 00000000", ram.addr); end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_lw();
    test_load_extract();
    test_lhu_slow();
    test_sb();
    test_read_wins();
    test_done_hold();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
